// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: one outstanding imem read, redirect squash, push into instruction queue.
// FETCH_CTRL_HOLD_BUF_EN adds a one-entry hold buffer (HOLD state) for responses that meet a full queue.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h6000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        iq_full,
  output logic        iq_push,
  output logic [31:0] iq_pc,
  output logic [31:0] iq_inst,
  output logic        busy
);

`ifdef FETCH_CTRL_HOLD_BUF_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_SQUASH = 2'd2, S_HOLD = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_SQUASH = 2'd2} state_t;
`endif

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic        w_issue_ok;
  logic        w_issue;
  logic        w_resp_push;
  logic        w_hold_push;
  logic [31:0] w_redir_pc;
  logic [31:0] w_next_pc;

  assign w_redir_pc = {redirect_pc[31:2], 2'b00};
  assign w_next_pc  = r_req_pc + 32'd4;

`ifdef FETCH_CTRL_HOLD_BUF_EN
  logic [31:0] r_hold_dat;
  assign w_issue_ok  = 1'b1;
  assign w_hold_push = (r_state == S_HOLD) && !redirect_valid && !iq_full;
`else
  assign w_issue_ok  = !iq_full;
  assign w_hold_push = 1'b0;
`endif

  // rst_n gates the issue so every output reads zero while reset is held
  assign w_issue     = rst_n && (r_state == S_IDLE) && !redirect_valid && w_issue_ok;
  assign w_resp_push = (r_state == S_WAIT) && imem_resp && !redirect_valid && !iq_full;

  assign imem_rmask = {4{w_issue}};
  assign imem_addr  = w_issue ? r_pc : 32'd0;
  assign iq_push    = w_resp_push || w_hold_push;
  assign iq_pc      = iq_push ? r_req_pc : 32'd0;
  assign busy       = (r_state != S_IDLE);

`ifdef FETCH_CTRL_HOLD_BUF_EN
  assign iq_inst = w_hold_push ? r_hold_dat : (w_resp_push ? imem_rdata : 32'd0);
`else
  assign iq_inst = w_resp_push ? imem_rdata : 32'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= 32'd0;
`ifdef FETCH_CTRL_HOLD_BUF_EN
      r_hold_dat <= 32'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (redirect_valid) begin
            r_pc <= w_redir_pc;
          end else if (w_issue) begin
            r_req_pc <= r_pc;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            r_pc    <= w_redir_pc;
            r_state <= imem_resp ? S_IDLE : S_SQUASH;
          end else if (imem_resp) begin
            if (!iq_full) begin
              r_pc    <= w_next_pc;
              r_state <= S_IDLE;
            end else begin
`ifdef FETCH_CTRL_HOLD_BUF_EN
              r_hold_dat <= imem_rdata;
              r_state    <= S_HOLD;
`else
              // response dropped; pc still equals req_pc so IDLE reissues it
              r_state <= S_IDLE;
`endif
            end
          end
        end
        S_SQUASH: begin
          if (redirect_valid) r_pc <= w_redir_pc;
          if (imem_resp) r_state <= S_IDLE;
        end
`ifdef FETCH_CTRL_HOLD_BUF_EN
        S_HOLD: begin
          if (redirect_valid) begin
            r_pc    <= w_redir_pc;
            r_state <= S_IDLE;
          end else if (!iq_full) begin
            r_pc    <= w_next_pc;
            r_state <= S_IDLE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed + randomized bench for fetch_ctrl against a transaction-level reference model.
module tb_fetch_ctrl;
  localparam logic [31:0] RST_PC = 32'h6000_0000;
  localparam logic [31:0] XORK   = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        iq_full;
  logic        iq_push;
  logic [31:0] iq_pc;
  logic [31:0] iq_inst;
  logic        busy;

  fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .iq_full(iq_full), .iq_push(iq_push), .iq_pc(iq_pc), .iq_inst(iq_inst),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Reference model: fetch pointer, one in-flight request (live or doomed), optional held word
  logic [31:0] m_pc;
  bit          m_pend;
  bit          m_live;
  logic [31:0] m_pend_pc;
  bit          m_held;
  logic [31:0] m_held_dat;

  logic [31:0] last_addr;
  bit          last_issue;
  bit          last_push;
  logic [31:0] last_push_pc;
  logic [31:0] last_push_inst;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_pend = 0; m_live = 0; m_pend_pc = '0; m_held = 0; m_held_dat = '0;
  endtask

  // Starts 2 time units after a rising edge, ends 2 time units after the next one
  task automatic step(input bit rv, input logic [31:0] rp, input bit rs, input bit fl);
    logic [31:0] rd;
    bit e_issue, e_push;
    logic [31:0] e_inst;
    rd = m_pend ? (m_pend_pc ^ XORK) : $urandom;
    redirect_valid = rv; redirect_pc = rp; imem_resp = rs; imem_rdata = rd; iq_full = fl;
    #3;
`ifdef FETCH_CTRL_HOLD_BUF_EN
    e_issue = !m_pend && !m_held && !rv;
`else
    e_issue = !m_pend && !m_held && !rv && !fl;
`endif
    e_push = !rv && !fl && ((m_pend && m_live && rs) || m_held);
    e_inst = m_held ? m_held_dat : rd;
    check("rmask", {28'd0, imem_rmask}, e_issue ? 32'hF : 32'h0);
    check("push", {31'd0, iq_push}, {31'd0, e_push});
    check("busy", {31'd0, busy}, {31'd0, (m_pend || m_held)});
    if (e_issue) check("addr", imem_addr, m_pc);
    if (e_push) begin
      check("iq_pc", iq_pc, m_pend_pc);
      check("iq_inst", iq_inst, e_inst);
    end
    last_issue = (imem_rmask == 4'hF);
    if (last_issue) last_addr = imem_addr;
    last_push = iq_push;
    if (iq_push) begin last_push_pc = iq_pc; last_push_inst = iq_inst; end
    if (rv) begin
      m_pc = rp & ~32'd3;
      if (m_pend && !rs) m_live = 0;
      else m_pend = 0;
      m_held = 0;
    end else if (m_held) begin
      if (!fl) begin m_held = 0; m_pc = m_pend_pc + 32'd4; end
    end else if (m_pend && rs) begin
      m_pend = 0;
      if (m_live) begin
        if (!fl) m_pc = m_pend_pc + 32'd4;
`ifdef FETCH_CTRL_HOLD_BUF_EN
        else begin m_held = 1; m_held_dat = rd; end
`endif
      end
    end else if (e_issue) begin
      m_pend = 1; m_live = 1; m_pend_pc = m_pc;
    end
    @(posedge clk); #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rmask"}, {28'd0, imem_rmask}, 32'h0);
    check({tag, "_push"}, {31'd0, iq_push}, 32'h0);
    check({tag, "_busy"}, {31'd0, busy}, 32'h0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_iqpc"}, iq_pc, 32'h0);
    check({tag, "_iqinst"}, iq_inst, 32'h0);
  endtask

  // Asserts reset mid-cycle, releases it mid-cycle one edge later
  task automatic do_reset();
    redirect_valid = 0; redirect_pc = '0; imem_resp = 0; imem_rdata = '0; iq_full = 0;
    rst_n = 0;
    #1;
    check_reset_outputs("rst_mid");
    model_reset();
    @(posedge clk); #2;
    rst_n = 1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    last_addr = '0; last_issue = 0; last_push = 0; last_push_pc = '0; last_push_inst = '0;
    model_reset();
    rst_n = 0; redirect_valid = 0; redirect_pc = '0; imem_resp = 0; imem_rdata = '0; iq_full = 0;
    #3;
    check_reset_outputs("rst0");
    @(posedge clk); #2;
    rst_n = 1;

    // Sequential fetch, response two cycles after each request
    step(0, 0, 0, 0);
    check("first_addr", last_addr, RST_PC);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    check("push0_pc", last_push_pc, 32'h6000_0000);
    check("push0_inst", last_push_inst, 32'hC5A5_A5A5);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 1, 0);
    end
    check("push2_pc", last_push_pc, 32'h6000_0008);

    // Redirect while waiting: late response squashed
    step(0, 0, 0, 0);
    step(1, 32'h8000_0010, 0, 0);
    step(0, 0, 1, 0);
    check("squash_nopush", {31'd0, last_push}, 32'h0);
    step(0, 0, 0, 0);
    check("redir_addr", last_addr, 32'h8000_0010);
    step(0, 0, 0, 0); step(0, 0, 1, 0);
    check("redir_push", last_push_pc, 32'h8000_0010);

    // Redirect coincident with response
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(1, 32'h7000_0000, 1, 0);
    check("coinc_nopush", {31'd0, last_push}, 32'h0);
    step(0, 0, 0, 0);
    check("coinc_addr", last_addr, 32'h7000_0000);
    step(0, 0, 1, 0);

    // Redirect in IDLE to unaligned top-of-space target, then wrap
    step(1, 32'hFFFF_FFFE, 0, 0);
    check("idle_redir_noissue", {31'd0, last_issue}, 32'h0);
    step(0, 0, 0, 0);
    check("wrap_addr0", last_addr, 32'hFFFF_FFFC);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check("wrap_addr1", last_addr, 32'h0000_0000);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Reset while a request is outstanding, stale response afterwards
    do_reset();
    step(0, 0, 1, 0);
    check("stale_nopush", {31'd0, last_push}, 32'h0);
    check("rst_reissue", last_addr, RST_PC);

    // Response meets a full queue
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    check("full_nopush", {31'd0, last_push}, 32'h0);
    step(0, 0, 0, 1);
    check("full_noissue", {31'd0, last_issue}, 32'h0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
`ifdef FETCH_CTRL_HOLD_BUF_EN
    check("hold_push", {31'd0, last_push}, 32'h1);
    check("hold_pc", last_push_pc, RST_PC);
`else
    check("drop_reissue", last_addr, RST_PC);
`endif

    for (int i = 0; i < 1500; i++) begin
      bit rv, rs, fl;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        rv = ($urandom_range(0, 9) == 0);
        fl = ($urandom_range(0, 3) == 0);
        rs = m_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
        step(rv, $urandom, rs, fl);
      end
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
